// File: rtl/reduce_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// reduce_ctrl_pkg
//   Shared types and helpers for the reduce-ALU scheduler.
//   - sched_state_t : scheduler FSM states
//   - alu_op_t      : 2-bit reduce ALU operation code
//   - len_w()       : width of a length field able to hold 0..n
// -----------------------------------------------------------------------------
package reduce_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    typedef logic [1:0] alu_op_t;

    // A length field must represent the full range 0..n inclusive.
    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The search begins at i_ptr, moves upward
//   and wraps at NREQ; the first asserted request found wins.
//   Ports:
//     i_req   [NREQ-1:0]          request levels
//     i_ptr   [$clog2(NREQ)-1:0]  highest-priority index for this pick
//     o_grant [NREQ-1:0]          one-hot winner (all zero when no request)
//     o_valid                     at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_grant,
    output logic                    o_valid
);

    always_comb begin
        int w_pos;
        logic w_found;
        o_grant = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_pos = int'(i_ptr) + i;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (!w_found && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/reduce_alu_sched.sv
// -----------------------------------------------------------------------------
// reduce_alu_sched
//   Shares one reduce_vector_alu among NREQ requesters. A round-robin winner's
//   operands are latched at grant, the ALU set/en/done protocol is sequenced,
//   a watchdog bounds the wait for alu_done, and the scalar result is returned
//   on a one-cycle per-requester response strobe.
//
//   Request/response handshake: req[i] is a level the requester holds high
//   until it sees rsp_valid[i]; rsp_valid[i] is a single-cycle strobe that
//   qualifies rsp_data and rsp_err. gnt is one-hot for the whole job. There is
//   no back-pressure on the response: the requester must accept it that cycle.
//
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     req/req_sel/req_len/req_vec  per-requester request and operands
//     gnt, rsp_valid        one-hot grant and completion strobe
//     rsp_data, rsp_err     result and error flag (qualified by rsp_valid)
//     alu_in/alu_in_len/alu_sel    latched operands driven to the ALU
//     alu_set, alu_en       ALU start pulse and enable
//     alu_out, alu_done     ALU result and completion
//     dbg_state             current scheduler state, for observation
// -----------------------------------------------------------------------------
module reduce_alu_sched
    import reduce_ctrl_pkg::*;
#(
    parameter int BITS    = 8,
    parameter int N       = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req,
    input  logic [NREQ-1:0][1:0]                req_sel,
    input  logic [NREQ-1:0][len_w(N)-1:0]       req_len,
    input  logic [NREQ-1:0][N-1:0][BITS-1:0]    req_vec,
    output logic [NREQ-1:0]                     gnt,
    output logic [NREQ-1:0]                     rsp_valid,
    output logic [BITS-1:0]                     rsp_data,
    output logic                                rsp_err,
    output logic [N-1:0][BITS-1:0]              alu_in,
    output logic [len_w(N)-1:0]                 alu_in_len,
    output logic [1:0]                          alu_sel,
    output logic                                alu_set,
    output logic                                alu_en,
    input  logic [BITS-1:0]                     alu_out,
    input  logic                                alu_done,
    output sched_state_t                        dbg_state
);

    localparam int LEN_W = len_w(N);
    localparam int IDX_W = $clog2(NREQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    sched_state_t                r_state;
    sched_state_t                w_next_state;
    logic [IDX_W-1:0]            r_ptr;
    logic [IDX_W-1:0]            r_idx;
    alu_op_t                     r_sel;
    logic [LEN_W-1:0]            r_len;
    logic [N-1:0][BITS-1:0]      r_vec;
    logic [BITS-1:0]             r_data;
    logic                        r_err;
    logic [WD_W-1:0]             r_wd;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NREQ-1:0]             w_arb_grant;
    logic                        w_arb_valid;
    logic [IDX_W-1:0]            w_win_idx;
    logic [LEN_W-1:0]            w_win_len;
    logic                        w_win_degen;
    logic                        w_win_bad;
    logic                        w_timeout;
    logic [NREQ-1:0]             w_idx_onehot;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_grant[i]) begin
                w_win_idx = IDX_W'(i);
            end
        end
    end

    assign w_win_len   = req_len[w_win_idx];
    assign w_win_bad   = (w_win_len > MAX_LEN);
    // Zero-length and over-length jobs never touch the ALU.
    assign w_win_degen = (w_win_len == '0) || w_win_bad;
    assign w_timeout   = (r_wd == WD_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. alu_done is looked at only in WAIT, so a level
    // left over from a previous job cannot complete the next one early.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_next_state = w_win_degen ? RESP : START;
                end
            end
            START: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                if (alu_done || w_timeout) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch at grant, watchdog, result capture, pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_idx  <= '0;
            r_sel  <= '0;
            r_len  <= '0;
            r_vec  <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
            r_wd   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_idx  <= w_win_idx;
                        r_sel  <= req_sel[w_win_idx];
                        r_len  <= w_win_len;
                        r_vec  <= req_vec[w_win_idx];
                        r_data <= '0;
                        r_err  <= w_win_bad;
                    end
                end
                START: begin
                    r_wd <= '0;
                end
                WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    // A done arriving on the timeout cycle still counts as success.
                    if (alu_done) begin
                        r_data <= alu_out;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_data <= '0;
                        r_err  <= 1'b1;
                    end
                end
                RESP: begin
                    r_ptr <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state so reset clears them at once
    // ------------------------------------------------------------------
    assign w_idx_onehot = NREQ'(1) << r_idx;

    assign gnt        = (r_state != IDLE) ? w_idx_onehot : '0;
    assign rsp_valid  = (r_state == RESP) ? w_idx_onehot : '0;
    assign rsp_data   = (r_state == RESP) ? r_data : '0;
    assign rsp_err    = (r_state == RESP) ? r_err : 1'b0;
    assign alu_in     = r_vec;
    assign alu_in_len = r_len;
    assign alu_sel    = r_sel;
    assign alu_set    = (r_state == START);
    assign alu_en     = (r_state == START) || (r_state == WAIT);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_reduce_alu_sched.sv
module tb_reduce_alu_sched;
  import reduce_ctrl_pkg::*;

  localparam int BITS    = 8;
  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int LEN_W   = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]                  req;
  logic [NREQ-1:0][1:0]             req_sel;
  logic [NREQ-1:0][LEN_W-1:0]       req_len;
  logic [NREQ-1:0][N-1:0][BITS-1:0] req_vec;
  logic [NREQ-1:0]                  gnt;
  logic [NREQ-1:0]                  rsp_valid;
  logic [BITS-1:0]                  rsp_data;
  logic                             rsp_err;
  logic [N-1:0][BITS-1:0]           alu_in;
  logic [LEN_W-1:0]                 alu_in_len;
  logic [1:0]                       alu_sel;
  logic                             alu_set;
  logic                             alu_en;
  logic [BITS-1:0]                  alu_out;
  logic                             alu_done;
  sched_state_t                     dbg_state;

  reduce_alu_sched #(
    .BITS(BITS), .N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_sel(req_sel), .req_len(req_len), .req_vec(req_vec),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_in(alu_in), .alu_in_len(alu_in_len), .alu_sel(alu_sel),
    .alu_set(alu_set), .alu_en(alu_en),
    .alu_out(alu_out), .alu_done(alu_done),
    .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard compare
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one cycle; sample and drive 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one ALU job with done sampled in the first WAIT cycle; starts in IDLE
  task automatic rr_job(input int idx, input logic [7:0] res);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    tick();
    chk("job_gnt", 64'(gnt), 64'(oh));
    chk("job_set", 64'(alu_set), 64'd1);
    tick();
    alu_done = 1'b1;
    alu_out  = res;
    tick();
    chk("job_rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("job_rsp_data", 64'(rsp_data), 64'(res));
    alu_done = 1'b0;
    tick();
    chk("job_idle", 64'(dbg_state), 64'(IDLE));
  endtask

  initial begin
    int seen;
    int c;
    req      = '0;
    req_sel  = '0;
    req_len  = '0;
    req_vec  = '0;
    alu_out  = '0;
    alu_done = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_alu_set", 64'(alu_set), 64'd0);
    chk("rst_alu_en", 64'(alu_en), 64'd0);
    chk("rst_alu_in", 64'(alu_in), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    tick();

    // single job on requester 2: done 3 cycles after set
    req[2]     = 1'b1;
    req_sel[2] = 2'b01;
    req_len[2] = 4'd4;
    req_vec[2] = 64'h00000000_04401203;
    tick();                                   // cycle 1
    chk("single_set", 64'(alu_set), 64'd1);
    chk("single_en", 64'(alu_en), 64'd1);
    chk("single_gnt", 64'(gnt), 64'b0100);
    chk("single_alu_in", 64'(alu_in), 64'h00000000_04401203);
    chk("single_len", 64'(alu_in_len), 64'd4);
    chk("single_sel", 64'(alu_sel), 64'd1);
    tick();                                   // cycle 2
    chk("single_set_c2", 64'(alu_set), 64'd0);
    chk("single_en_c2", 64'(alu_en), 64'd1);
    tick();                                   // cycle 3
    chk("single_set_c3", 64'(alu_set), 64'd0);
    chk("single_nrsp_c3", 64'(rsp_valid), 64'd0);
    tick();                                   // cycle 4
    alu_done = 1'b1;
    alu_out  = 8'h59;
    chk("single_nrsp_c4", 64'(rsp_valid), 64'd0);
    tick();                                   // cycle 5
    chk("single_rsp_valid", 64'(rsp_valid), 64'b0100);
    chk("single_rsp_data", 64'(rsp_data), 64'h59);
    chk("single_rsp_err", 64'(rsp_err), 64'd0);
    chk("single_en_resp", 64'(alu_en), 64'd0);
    chk("single_set_resp", 64'(alu_set), 64'd0);
    alu_done = 1'b0;
    req      = '0;
    tick();                                   // cycle 6
    chk("single_rsp_once", 64'(rsp_valid), 64'd0);
    chk("single_idle", 64'(dbg_state), 64'(IDLE));

    // degenerate len=0 on requester 3
    req[3]     = 1'b1;
    req_len[3] = 4'd0;
    tick();
    chk("len0_rsp_valid", 64'(rsp_valid), 64'b1000);
    chk("len0_data", 64'(rsp_data), 64'd0);
    chk("len0_err", 64'(rsp_err), 64'd0);
    chk("len0_noset", 64'(alu_set), 64'd0);
    req = '0;
    tick();
    chk("len0_idle", 64'(dbg_state), 64'(IDLE));

    // degenerate len=9 on requester 3
    req[3]     = 1'b1;
    req_len[3] = 4'd9;
    tick();
    chk("len9_rsp_valid", 64'(rsp_valid), 64'b1000);
    chk("len9_data", 64'(rsp_data), 64'd0);
    chk("len9_err", 64'(rsp_err), 64'd1);
    chk("len9_noset", 64'(alu_set), 64'd0);
    req = '0;
    tick();
    chk("len9_noset_after", 64'(alu_set), 64'd0);

    // round robin, all requesting, pointer at 0
    req_len = {4'd2, 4'd2, 4'd2, 4'd2};
    req     = 4'b1111;
    rr_job(0, 8'h10);
    rr_job(1, 8'h11);
    rr_job(2, 8'h12);
    rr_job(3, 8'h13);
    rr_job(0, 8'h20);
    // pointer now 1: requester 3 is ahead of 0
    req = 4'b1001;
    rr_job(3, 8'h33);
    rr_job(0, 8'h30);
    req = '0;
    tick();

    // timeout on requester 1 (pointer at 1)
    req[1]     = 1'b1;
    req_len[1] = 4'd3;
    seen = -1;
    c    = 0;
    while (seen < 0 && c < 80) begin
      tick();
      c++;
      if (c == 65) chk("tmo_en_c65", 64'(alu_en), 64'd1);
      if (rsp_valid != '0) begin
        seen = c;
        chk("tmo_rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("tmo_err", 64'(rsp_err), 64'd1);
        chk("tmo_data", 64'(rsp_data), 64'd0);
        chk("tmo_en_resp", 64'(alu_en), 64'd0);
      end
    end
    chk("tmo_cycle", 64'(seen), 64'd66);
    req = '0;
    tick();
    chk("tmo_en_after", 64'(alu_en), 64'd0);

    // stale done held high, operands changed after grant (pointer at 2)
    alu_done   = 1'b1;
    alu_out    = 8'hEE;
    req_sel[2] = 2'd2;
    req_len[2] = 4'd3;
    req_vec[2] = 64'h00000000_00030201;
    req_sel[3] = 2'd3;
    req_len[3] = 4'd3;
    req_vec[3] = 64'h00000000_00C0B0A0;
    req        = 4'b1100;
    tick();                                   // START for 2
    chk("stale_gnt2", 64'(gnt), 64'b0100);
    chk("stale_in2_start", 64'(alu_in), 64'h00000000_00030201);
    chk("stale_sel2", 64'(alu_sel), 64'd2);
    req_vec[2] = 64'hFFFFFFFF_FFFFFFFF;
    tick();                                   // WAIT: done ignored in START
    chk("stale_wait2", 64'(dbg_state), 64'(WAIT));
    chk("stale_nrsp2", 64'(rsp_valid), 64'd0);
    chk("stale_in2_wait", 64'(alu_in), 64'h00000000_00030201);
    alu_out = 8'h77;
    tick();                                   // RESP
    chk("stale_rsp2", 64'(rsp_valid), 64'b0100);
    chk("stale_data2", 64'(rsp_data), 64'h77);
    req[2] = 1'b0;
    tick();                                   // IDLE, grants 3
    chk("stale_idle", 64'(dbg_state), 64'(IDLE));
    tick();                                   // START for 3
    chk("stale_gnt3", 64'(gnt), 64'b1000);
    chk("stale_nrsp3", 64'(rsp_valid), 64'd0);
    chk("stale_in3_start", 64'(alu_in), 64'h00000000_00C0B0A0);
    req_vec[3] = 64'h12345678_9ABCDEF0;
    tick();                                   // WAIT
    chk("stale_wait3", 64'(dbg_state), 64'(WAIT));
    chk("stale_in3_wait", 64'(alu_in), 64'h00000000_00C0B0A0);
    alu_out = 8'h3C;
    tick();                                   // RESP
    chk("stale_rsp3", 64'(rsp_valid), 64'b1000);
    chk("stale_data3", 64'(rsp_data), 64'h3C);
    req      = '0;
    alu_done = 1'b0;
    tick();

    // reset asserted in WAIT
    req[1]     = 1'b1;
    req_len[1] = 4'd2;
    req_vec[1] = 64'h00000000_00005555;
    tick();                                   // START
    tick();                                   // WAIT
    chk("rstw_in_wait", 64'(dbg_state), 64'(WAIT));
    rst = 1'b1;
    tick();
    chk("rstw_gnt", 64'(gnt), 64'd0);
    chk("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstw_set", 64'(alu_set), 64'd0);
    chk("rstw_en", 64'(alu_en), 64'd0);
    chk("rstw_alu_in", 64'(alu_in), 64'd0);
    chk("rstw_len", 64'(alu_in_len), 64'd0);
    chk("rstw_sel", 64'(alu_sel), 64'd0);
    chk("rstw_data", 64'(rsp_data), 64'd0);
    chk("rstw_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    rr_job(1, 8'hA5);
    req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reduce_alu_sched.md
# reduce_alu_sched

Round-robin scheduler that shares one `reduce_vector_alu` among `NREQ` requesters, such as host-HAL command ports or vector-engine lanes. It latches the winning requester's operands and sequences the ALU's `set`/`en`/`done` protocol. The block guards each job with a watchdog and returns the scalar result on a per-requester one-cycle response strobe. It sits between the request fabric and the single reduce ALU instance.

## Interface
Parameters:
- `BITS`, 8: element and result width.
- `N`, 8: maximum vector length (ALU lanes).
- `NREQ`, 4: number of requesters, ≥2.
- `TIMEOUT`, 64: maximum cycles spent waiting for `alu_done`.

Ports:
- `clk` in, 1: single clock; everything is on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `req` in, [NREQ-1:0]: request level. Held high until that requester's `rsp_valid`.
- `req_sel` in, [NREQ-1:0][1:0]: ALU op per requester.
- `req_len` in, [NREQ-1:0][$clog2(N+1)-1:0]: element count per requester.
- `req_vec` in, [NREQ-1:0][N-1:0][BITS-1:0]: operand vector per requester.
- `gnt` out, [NREQ-1:0]: one-hot grant, high for the whole job.
- `rsp_valid` out, [NREQ-1:0]: one-cycle completion strobe.
- `rsp_data` out, BITS: result, valid only while any `rsp_valid` is high.
- `rsp_err` out, 1: error flag qualified by `rsp_valid` (timeout or `len>N`).
- `alu_in` out, [N-1:0][BITS-1:0]: latched operands to the ALU.
- `alu_in_len` out, $clog2(N+1): latched length.
- `alu_sel` out, 2: latched op.
- `alu_set` out, 1: one-cycle start pulse.
- `alu_en` out, 1: ALU enable, high during START and WAIT.
- `alu_out` in, BITS: ALU result.
- `alu_done` in, 1: ALU completion. Sampled only in WAIT.

## Operation
- FSM states: IDLE → START → WAIT → RESP → IDLE. RESP is also entered directly from IDLE for degenerate jobs.
- **IDLE**
  - If `req` is non-zero, pick the winner by round robin. Search starts at `ptr`, wraps at NREQ, lowest index first from `ptr`.
  - Latch the winner's sel/len/vec into operand registers and latch its index. Set `gnt[idx]`.
  - `len==0` → RESP with data 0, err 0.
  - `len>N` → RESP with data 0, err 1.
  - Otherwise → START.
- **START**: `alu_set=1` and `alu_en=1` for exactly one cycle. Clear the watchdog. → WAIT.
- **WAIT**
  - `alu_en=1`; the watchdog increments each cycle.
  - `alu_done=1` → capture `alu_out` into `rsp_data`, err 0, → RESP.
  - Watchdog reaches `TIMEOUT-1` without `alu_done` → data 0, err 1, → RESP.
  - If `alu_done` and timeout occur in the same cycle, `alu_done` wins.
- **RESP**
  - `rsp_valid[idx]=1` for one cycle and `gnt` is cleared.
  - Set `ptr` to `idx+1` mod NREQ. → IDLE.
- Operands are registered at grant. Changes on `req_*` after grant do not affect the running job.
- If `req[idx]` drops mid-job, the job still completes and the response still pulses.
- A new `req` never preempts a job in progress.
- `alu_done` seen in IDLE, START or RESP is ignored (it is a stale level from the previous job).

## Timing
- Reset values: state IDLE, `ptr`=0, and `gnt`, `rsp_valid`, `rsp_data`, `rsp_err`, `alu_set`, `alu_en`, `alu_in`, `alu_in_len`, `alu_sel` all 0.
- A reset asserted mid-job aborts the job silently: no `rsp_valid`, `alu_set`/`alu_en` low the next cycle.
- Normal job, with request sampled at cycle 0:
  - cycles 1 and later: `gnt` high.
  - cycle 1: START, `alu_set` high.
  - cycles 2 and later: WAIT.
  - `alu_done` sampled at cycle k ≥ 2 → `rsp_valid` at k+1.
  - k+2: IDLE; the next grant is visible at k+3.
- Degenerate length: `rsp_valid` at cycle 1.
- Timeout: `rsp_valid` at cycle 2+TIMEOUT.
- Throughput: 1 job per (ALU latency + 3) cycles.

## Structure
- Package `reduce_ctrl_pkg`:
  - `sched_state_t` enum {IDLE, START, WAIT, RESP}.
  - `alu_op_t` (2-bit).
  - Width helper `LEN_W = $clog2(N+1)`.
- Sub-module `rr_arbiter #(NREQ)`: purely combinational. Takes `req` and `ptr`, returns the one-hot winner and a valid. Instantiated once.

## Test plan
- **Single job.** Stimulus: `req[2]`, sel=01, len=4, vec {03,12,40,04}; ALU stub raises `alu_done` 3 cycles after `alu_set` with `alu_out`=8'h59. Required response:
  - `alu_set` pulses once.
  - `alu_in`/`alu_in_len`/`alu_sel` match the request.
  - `rsp_valid[2]` pulses once with `rsp_data`=59 and err 0.
- **Round robin.**
  - `req`=4'b1111 held, `ptr`=0 → grant order 0,1,2,3,0.
  - Then `req`=4'b1001 with `ptr`=1 → 3 is granted before 0.
- **Degenerate lengths.**
  - len=0 → `rsp_valid` at cycle 1, data 0, err 0, no `alu_set`.
  - len=9 with N=8 → err 1, no `alu_set`.
- **Timeout.** ALU stub never raises `alu_done`, TIMEOUT=64 → `rsp_err=1` and `rsp_valid` exactly at cycle 66; `alu_en` low afterwards.
- **Stale done and operand isolation.** Stimulus: `alu_done` held high across jobs; `req_vec` changed one cycle after grant. Required response: done is ignored in START; the second job's result comes from the latched operands.
- **Reset mid-WAIT.** `rst` pulses in WAIT → next cycle all outputs 0, no `rsp_valid`; the next request is served normally.
